// File: rtl/packet_pkg.sv
// Shared switch definitions: port count, input-index width and the
// per-packet output target mask type.
package packet_pkg;

   localparam int NUM_PORTS  = 4;
   localparam int PORT_SEL_W = $clog2(NUM_PORTS);

   typedef logic [NUM_PORTS-1:0] port_mask_t;

endpackage

// File: rtl/switch_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first set bit of
// req_i, scanning upward from ptr_i and wrapping at NUM_PORTS.
// Ports: req_i (request mask), ptr_i (scan start),
//        gnt_valid_o (any request), gnt_idx_o (winning index).
module rr_arbiter
   import packet_pkg::*;
#(
   parameter int NUM_PORTS = packet_pkg::NUM_PORTS,
   localparam int SEL_W    = $clog2(NUM_PORTS)
) (
   input  logic [NUM_PORTS-1:0] req_i,
   input  logic [SEL_W-1:0]     ptr_i,
   output logic                 gnt_valid_o,
   output logic [SEL_W-1:0]     gnt_idx_o
);

   int w_j;

   // Scan from the farthest offset down to offset 0 so that the last
   // hit written is the one closest to ptr_i.
   always_comb begin
      gnt_valid_o = 1'b0;
      gnt_idx_o   = '0;
      w_j         = 0;
      for (int k = NUM_PORTS - 1; k >= 0; k--) begin
         w_j = (int'(ptr_i) + k) % NUM_PORTS;
         if (req_i[w_j]) begin
            gnt_valid_o = 1'b1;
            gnt_idx_o   = SEL_W'(w_j);
         end
      end
   end

endmodule

// File: rtl/switch_scheduler.sv
// switch_scheduler: per-output round-robin crossbar scheduler with
// multicast masks; grants, pops and drops are combinational (zero latency).
// Ports: clk, rst_n (sync, active-low); req_valid_i/req_target_i (HOL
// packet per input); out_ready_i (per output); out_en_o/out_sel_o
// (crossbar control); pop_o (HOL complete); drop_o (zero-mask discard).
module switch_scheduler
   import packet_pkg::*;
#(
   parameter int NUM_PORTS = packet_pkg::NUM_PORTS,
   localparam int SEL_W    = $clog2(NUM_PORTS)
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [NUM_PORTS-1:0]           req_valid_i,
   input  logic [NUM_PORTS*NUM_PORTS-1:0] req_target_i,
   input  logic [NUM_PORTS-1:0]           out_ready_i,
   output logic [NUM_PORTS-1:0]           out_en_o,
   output logic [NUM_PORTS*SEL_W-1:0]     out_sel_o,
   output logic [NUM_PORTS-1:0]           pop_o,
   output logic [NUM_PORTS-1:0]           drop_o
);

   // r_served[i][o]: output o already carried the HOL packet of input i
   logic [NUM_PORTS-1:0] r_served [NUM_PORTS];
   logic [SEL_W-1:0]     r_ptr    [NUM_PORTS];

   logic [NUM_PORTS-1:0] w_mask [NUM_PORTS];
   // w_cand[o][i]: input i competes for output o (ready folded in)
   logic [NUM_PORTS-1:0] w_cand [NUM_PORTS];
   // w_gnt[i][o]: output o granted to input i this cycle
   logic [NUM_PORTS-1:0] w_gnt  [NUM_PORTS];
   logic [NUM_PORTS-1:0] w_gvld;
   logic [SEL_W-1:0]     w_gidx [NUM_PORTS];
   logic [NUM_PORTS-1:0] w_done;
   logic [NUM_PORTS-1:0] w_drop;

   for (genvar i = 0; i < NUM_PORTS; i++) begin : g_mask
      assign w_mask[i] = req_target_i[i*NUM_PORTS +: NUM_PORTS];
   end

   always_comb begin
      for (int o = 0; o < NUM_PORTS; o++) begin
         w_cand[o] = '0;
         for (int i = 0; i < NUM_PORTS; i++) begin
            w_cand[o][i] = req_valid_i[i] && w_mask[i][o] &&
                           !r_served[i][o] && out_ready_i[o];
         end
      end
   end

   for (genvar o = 0; o < NUM_PORTS; o++) begin : g_arb
      rr_arbiter #(
         .NUM_PORTS (NUM_PORTS)
      ) u_arb (
         .req_i       (w_cand[o]),
         .ptr_i       (r_ptr[o]),
         .gnt_valid_o (w_gvld[o]),
         .gnt_idx_o   (w_gidx[o])
      );
   end

   always_comb begin
      for (int i = 0; i < NUM_PORTS; i++) begin
         w_gnt[i] = '0;
         for (int o = 0; o < NUM_PORTS; o++) begin
            w_gnt[i][o] = w_gvld[o] && (w_gidx[o] == SEL_W'(i));
         end
         w_drop[i] = req_valid_i[i] && (w_mask[i] == '0);
         w_done[i] = req_valid_i[i] && (w_mask[i] != '0) &&
                     ((r_served[i] | w_gnt[i]) == w_mask[i]);
      end
   end

   always_comb begin
      out_en_o  = '0;
      out_sel_o = '0;
      pop_o     = '0;
      drop_o    = '0;
      if (rst_n) begin
         out_en_o = w_gvld;
         for (int o = 0; o < NUM_PORTS; o++) begin
            if (w_gvld[o]) begin
               out_sel_o[o*SEL_W +: SEL_W] = w_gidx[o];
            end
         end
         pop_o  = w_done | w_drop;
         drop_o = w_drop;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int k = 0; k < NUM_PORTS; k++) begin
            r_served[k] <= '0;
            r_ptr[k]    <= '0;
         end
      end else begin
         for (int o = 0; o < NUM_PORTS; o++) begin
            if (w_gvld[o]) begin
               r_ptr[o] <= (w_gidx[o] == SEL_W'(NUM_PORTS - 1)) ?
                           '0 : w_gidx[o] + 1'b1;
            end
         end
         // a dropped valid abandons any partial multicast progress
         for (int i = 0; i < NUM_PORTS; i++) begin
            if (!req_valid_i[i] || w_done[i]) begin
               r_served[i] <= '0;
            end else begin
               r_served[i] <= r_served[i] | w_gnt[i];
            end
         end
      end
   end

   for (genvar i = 0; i < NUM_PORTS; i++) begin : g_chk
      a_mask_stable: assert property (
         @(posedge clk) disable iff (!rst_n)
         (req_valid_i[i] && !pop_o[i]) ##1 req_valid_i[i]
         |-> $stable(w_mask[i])
      );
   end

endmodule

// File: tb/tb_switch_scheduler.sv
// Bench for switch_scheduler: directed scenarios plus randomized traffic,
// checked against a queue-based model of outstanding output obligations.
module tb_switch_scheduler;
   import packet_pkg::*;

   localparam int N  = NUM_PORTS;
   localparam int SW = PORT_SEL_W;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [N-1:0]    req_valid;
   logic [N*N-1:0]  req_target;
   logic [N-1:0]    out_ready;
   logic [N-1:0]    out_en;
   logic [N*SW-1:0] out_sel;
   logic [N-1:0]    pop;
   logic [N-1:0]    drop;

   switch_scheduler #(
      .NUM_PORTS (N)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_valid_i  (req_valid),
      .req_target_i (req_target),
      .out_ready_i  (out_ready),
      .out_en_o     (out_en),
      .out_sel_o    (out_sel),
      .pop_o        (pop),
      .drop_o       (drop)
   );

   always #5 clk = ~clk;

   // packets waiting at each input; head is the HOL packet
   port_mask_t q [N][$];
   // outputs still owed to a partially served head packet
   port_mask_t owed [N];
   bit         fresh [N];
   // most recent winner per output; N-1 means the scan starts at 0
   int         last [N];

   int n_chk = 0;
   int n_err = 0;

   logic [N-1:0]    obs_en, obs_pop, obs_drop;
   logic [N*SW-1:0] obs_sel;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         fresh[i] = 1'b1;
         owed[i]  = '0;
         last[i]  = N - 1;
      end
   endtask

   task automatic step(input string tag);
      port_mask_t      m   [N];
      port_mask_t      rem [N];
      port_mask_t      gnt [N];
      int              win [N];
      logic [N-1:0]    e_en, e_pop, e_drop;
      logic [N*SW-1:0] e_sel;
      int              idx;
      for (int i = 0; i < N; i++) begin
         req_valid[i] = (q[i].size() > 0);
         m[i] = req_valid[i] ? q[i][0] : port_mask_t'($urandom);
         req_target[i*N +: N] = m[i];
      end
      #3;
      e_en = '0; e_pop = '0; e_drop = '0; e_sel = '0;
      for (int i = 0; i < N; i++) begin
         gnt[i] = '0;
         win[i] = -1;
         rem[i] = fresh[i] ? m[i] : owed[i];
      end
      if (rst_n) begin
         for (int o = 0; o < N; o++) begin
            for (int k = 0; k < N; k++) begin
               idx = (last[o] + 1 + k) % N;
               if (out_ready[o] && win[o] < 0 && req_valid[idx] &&
                   rem[idx][o]) begin
                  win[o]   = idx;
                  e_en[o]  = 1'b1;
                  e_sel[o*SW +: SW] = SW'(idx);
                  gnt[idx][o] = 1'b1;
               end
            end
         end
         for (int i = 0; i < N; i++) begin
            if (req_valid[i] && m[i] == '0) begin
               e_drop[i] = 1'b1;
               e_pop[i]  = 1'b1;
            end else if (req_valid[i] && (rem[i] & ~gnt[i]) == '0) begin
               e_pop[i] = 1'b1;
            end
         end
      end
      obs_en = out_en; obs_sel = out_sel; obs_pop = pop; obs_drop = drop;
      chk({tag, "/en"},   32'(out_en), 32'(e_en));
      chk({tag, "/sel"},  32'(out_sel), 32'(e_sel));
      chk({tag, "/pop"},  32'(pop), 32'(e_pop));
      chk({tag, "/drop"}, 32'(drop), 32'(e_drop));
      @(posedge clk);
      if (!rst_n) begin
         model_reset();
      end else begin
         for (int o = 0; o < N; o++) begin
            if (win[o] >= 0) last[o] = win[o];
         end
         for (int i = 0; i < N; i++) begin
            if (e_pop[i]) begin
               void'(q[i].pop_front());
               fresh[i] = 1'b1;
            end else if (req_valid[i]) begin
               owed[i]  = rem[i] & ~gnt[i];
               fresh[i] = 1'b0;
            end else begin
               fresh[i] = 1'b1;
            end
         end
      end
      #1;
   endtask

   task automatic do_reset(input int n);
      rst_n = 1'b0;
      repeat (n) step("rst");
      rst_n = 1'b1;
   endtask

   initial begin
      int seq [6] = '{0, 2, 3, 0, 2, 3};
      rst_n      = 1'b0;
      req_valid  = '0;
      req_target = '0;
      out_ready  = '1;
      model_reset();
      #1;

      // T1: reset with every input requesting all outputs
      for (int i = 0; i < N; i++) q[i].push_back(4'hF);
      rst_n = 1'b0;
      for (int c = 0; c < 5; c++) begin
         step("t1_rst");
         chk("t1_rst_en", 32'(obs_en), 32'h0);
         chk("t1_rst_pop", 32'(obs_pop), 32'h0);
      end
      rst_n = 1'b1;
      step("t1_rel");
      chk("t1_rel_en", 32'(obs_en), 32'hF);
      chk("t1_rel_sel", 32'(obs_sel), 32'h0);
      chk("t1_rel_pop", 32'(obs_pop), 32'h1);
      repeat (3) step("t1_drain");

      // T2: unicast
      do_reset(2);
      q[0].push_back(4'b0010);
      step("t2");
      chk("t2_en", 32'(obs_en), 32'h2);
      chk("t2_sel1", 32'(obs_sel[SW +: SW]), 32'h0);
      chk("t2_pop", 32'(obs_pop), 32'h1);

      // T3: three inputs contend for output 0
      do_reset(2);
      for (int r = 0; r < 2; r++) begin
         q[0].push_back(4'b0001);
         q[2].push_back(4'b0001);
         q[3].push_back(4'b0001);
      end
      for (int c = 0; c < 6; c++) begin
         step("t3");
         chk("t3_sel0", 32'(obs_sel[0 +: SW]), 32'(seq[c]));
         chk("t3_npop", 32'($countones(obs_pop)), 32'd1);
      end

      // T4: multicast with backpressure on output 3
      do_reset(2);
      q[1].push_back(4'b1101);
      out_ready = 4'b0111;
      step("t4_c0");
      chk("t4_c0_en", 32'(obs_en), 32'h5);
      chk("t4_c0_pop", 32'(obs_pop), 32'h0);
      step("t4_c1");
      chk("t4_c1_en", 32'(obs_en), 32'h0);
      out_ready = '1;
      step("t4_c2");
      chk("t4_c2_en", 32'(obs_en), 32'h8);
      chk("t4_c2_pop", 32'(obs_pop), 32'h2);

      // T5: zero mask is dropped
      q[2].push_back(4'b0000);
      step("t5");
      chk("t5_drop", 32'(obs_drop), 32'h4);
      chk("t5_pop", 32'(obs_pop), 32'h4);
      chk("t5_en", 32'(obs_en), 32'h0);

      // T6: reset in the middle of a multicast
      do_reset(2);
      q[1].push_back(4'b1101);
      out_ready = 4'b0111;
      step("t6_c0");
      chk("t6_c0_en", 32'(obs_en), 32'h5);
      rst_n = 1'b0;
      step("t6_rst");
      rst_n = 1'b1;
      out_ready = '1;
      step("t6_rel");
      chk("t6_rel_en", 32'(obs_en), 32'hD);
      chk("t6_rel_pop", 32'(obs_pop), 32'h2);

      // randomized traffic, readiness and occasional resets
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < N; i++) begin
            if (q[i].size() < 3 && $urandom_range(0, 2) == 0) begin
               if ($urandom_range(0, 9) == 0) q[i].push_back(4'h0);
               else q[i].push_back(port_mask_t'($urandom_range(1, 15)));
            end
         end
         out_ready = N'($urandom | $urandom);
         rst_n = ($urandom_range(0, 59) != 0);
         step("rnd");
      end

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
